// File: rtl/addr_trace_fifo.sv
// Elastic FIFO between the z80 address tracer and the UART: stores 16-bit addresses
// and sends each one as hi/lo bytes. Define TRACE_SYNC_EN to put a SYNC byte before each word.
module addr_trace_fifo #(
  parameter int          AW   = 4,
  parameter logic [7:0]  SYNC = 8'h55
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [15:0]   in_addr,
  output logic          in_ready,
  output logic [7:0]    tx_data,
  output logic          tx_wr,
  input  logic          tx_done,
  output logic [AW:0]   level,
  output logic          busy,
  output logic          overflow,
  output logic [7:0]    drop_cnt
);

  localparam int          DEPTH    = 2 ** AW;
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1'b1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HI     = 3'd3;
  localparam logic [2:0] S_HI_W   = 3'd4;
  localparam logic [2:0] S_LO     = 3'd5;
  localparam logic [2:0] S_LO_W   = 3'd6;
`ifdef TRACE_SYNC_EN
  localparam logic [2:0] S_SYNC   = 3'd1;
  localparam logic [2:0] S_SYNC_W = 3'd2;
  localparam logic [2:0] S_FIRST  = S_SYNC;
`else
  localparam logic [2:0] S_FIRST  = S_HI;
  logic unused_sync_s;
  assign unused_sync_s = ^SYNC;
`endif

  logic [15:0]   mem_r [0:DEPTH-1];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   level_r;
  logic [15:0]   word_r;
  logic [2:0]    state_r;
  logic [2:0]    state_nxt_s;
  logic [7:0]    tx_data_r;
  logic          tx_wr_r;
  logic          busy_r;
  logic          overflow_r;
  logic [7:0]    drop_cnt_r;
  logic          done_lat_r;

  logic          full_s;
  logic          wr_en_s;
  logic          drop_s;
  logic          pop_s;
  logic          tx_issue_s;
  logic [7:0]    tx_byte_s;

  // Write acceptance is judged on the level at the start of the cycle, so a same-cycle pop never rescues a write.
  always_comb begin
    full_s  = (level_r == LVL_FULL);
    wr_en_s = in_valid && !full_s;
    drop_s  = in_valid && full_s;
    pop_s   = (state_r == S_IDLE) && (level_r != LVL_ZERO);
  end

  // Serialiser next-state and the byte to launch when a tx_wr is issued.
  always_comb begin
    state_nxt_s = state_r;
    tx_issue_s  = 1'b0;
    tx_byte_s   = 8'h00;
    case (state_r)
      S_IDLE: begin
        if (pop_s) begin
          state_nxt_s = S_FIRST;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
`ifdef TRACE_SYNC_EN
      S_SYNC: begin
        tx_issue_s  = 1'b1;
        tx_byte_s   = SYNC;
        state_nxt_s = S_SYNC_W;
      end
      S_SYNC_W: begin
        if (done_lat_r) begin
          state_nxt_s = S_HI;
        end else begin
          state_nxt_s = S_SYNC_W;
        end
      end
`endif
      S_HI: begin
        tx_issue_s  = 1'b1;
        tx_byte_s   = word_r[15:8];
        state_nxt_s = S_HI_W;
      end
      S_HI_W: begin
        if (done_lat_r) begin
          state_nxt_s = S_LO;
        end else begin
          state_nxt_s = S_HI_W;
        end
      end
      S_LO: begin
        tx_issue_s  = 1'b1;
        tx_byte_s   = word_r[7:0];
        state_nxt_s = S_LO_W;
      end
      S_LO_W: begin
        if (done_lat_r) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_LO_W;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // FIFO storage; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= in_addr;
    end
  end

  // Pointers, occupancy and drop bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      level_r    <= LVL_ZERO;
      overflow_r <= 1'b0;
      drop_cnt_r <= 8'h00;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_en_s, pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
        if (drop_cnt_r != 8'hFF) begin
          drop_cnt_r <= drop_cnt_r + 8'd1;
        end
      end
    end
  end

  // Serialiser state, word register and UART-facing outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      word_r    <= 16'h0000;
      tx_data_r <= 8'h00;
      tx_wr_r   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != S_IDLE);
      tx_wr_r <= tx_issue_s;
      if (pop_s) begin
        word_r <= mem_r[rd_ptr_r];
      end
      if (tx_issue_s) begin
        tx_data_r <= tx_byte_s;
      end
    end
  end

  // tx_done latch: a pulse landing in the same cycle as the clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_lat_r <= 1'b0;
    end else if (tx_done) begin
      done_lat_r <= 1'b1;
    end else if (tx_issue_s) begin
      done_lat_r <= 1'b0;
    end else begin
      done_lat_r <= done_lat_r;
    end
  end

  assign in_ready = !full_s;
  assign tx_data  = tx_data_r;
  assign tx_wr    = tx_wr_r;
  assign level    = level_r;
  assign busy     = busy_r;
  assign overflow = overflow_r;
  assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_addr_trace_fifo.sv
// Self-checking bench for addr_trace_fifo: directed vectors, corner sequences and
// randomized traffic checked against a byte-stream model with a UART responder.
module tb_addr_trace_fifo;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
`ifdef TRACE_SYNC_EN
  localparam int BPW = 3;
`else
  localparam int BPW = 2;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [15:0]   in_addr;
  logic          in_ready;
  logic [7:0]    tx_data;
  logic          tx_wr;
  logic          tx_done = 1'b0;
  logic [AW:0]   level;
  logic          busy;
  logic          overflow;
  logic [7:0]    drop_cnt;

  addr_trace_fifo #(.AW(AW), .SYNC(8'h55)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_addr  (in_addr),
    .in_ready (in_ready),
    .tx_data  (tx_data),
    .tx_wr    (tx_wr),
    .tx_done  (tx_done),
    .level    (level),
    .busy     (busy),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  bit         ack_en    = 1'b1;
  int         ack_delay = 20;
  int         done_cnt  = 0;
  bit         pend      = 1'b0;
  bit         prev_wr   = 1'b0;
  int         ack_cnt   = 0;
  logic [7:0] held      = 8'h00;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  exp_hi;
    logic [7:0]  exp_lo;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: actual=timeout required=event", name);
  endtask

  // UART model: records each launched byte, checks pulse width and data hold, acks after a delay.
  always @(negedge clk) begin
    tx_done = 1'b0;
    if (rst) begin
      pend    = 1'b0;
      prev_wr = 1'b0;
    end else begin
      if (tx_wr) begin
        got_q.push_back(tx_data);
        check("tx_wr_one_cycle", {31'd0, prev_wr}, 32'd0);
        pend    = 1'b1;
        held    = tx_data;
        ack_cnt = (ack_delay == 0) ? $urandom_range(1, 6) : ack_delay;
      end else if (pend && ack_en) begin
        check("tx_data_hold", {24'd0, tx_data}, {24'd0, held});
        if (ack_cnt <= 1) begin
          tx_done  = 1'b1;
          pend     = 1'b0;
          done_cnt++;
        end else begin
          ack_cnt--;
        end
      end
      prev_wr = tx_wr;
    end
  end

  task automatic write_word(input logic [15:0] a);
    in_valid = 1'b1;
    in_addr  = a;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic push_word(input logic [15:0] a);
`ifdef TRACE_SYNC_EN
    exp_q.push_back(8'h55);
`endif
    exp_q.push_back(a[15:8]);
    exp_q.push_back(a[7:0]);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(level == '0 && busy == 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) fail_timeout("wait_idle");
  endtask

  task automatic check_stream(input string name);
    check({name, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", name, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_level"},    {27'd0, level},    32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_tx_wr"},    {31'd0, tx_wr},    32'd0);
    check({tag, "_tx_data"},  {24'd0, tx_data},  32'd0);
    check({tag, "_busy"},     {31'd0, busy},     32'd0);
    check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
    check({tag, "_drop_cnt"}, {24'd0, drop_cnt}, 32'd0);
  endtask

  initial begin
    int n;
    int wr;
    int d0;
    logic [15:0] a;

    vecs[0] = '{16'h1234, 8'h12, 8'h34};
    vecs[1] = '{16'h0000, 8'h00, 8'h00};
    vecs[2] = '{16'hFFFF, 8'hFF, 8'hFF};
    vecs[3] = '{16'h00FF, 8'h00, 8'hFF};
    vecs[4] = '{16'hA55A, 8'hA5, 8'h5A};
    vecs[5] = '{16'h8001, 8'h80, 8'h01};

    rst = 1'b1;
    in_valid = 1'b0;
    in_addr = 16'h0000;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single words, slow UART: hi then lo (SYNC first when built in).
    ack_en = 1'b1;
    ack_delay = 20;
    foreach (vecs[k]) begin
      got_q.delete();
      write_word(vecs[k].addr);
      wait_idle(300);
      check($sformatf("vec%0d_pulses", k), got_q.size(), BPW);
      if (got_q.size() == BPW) begin
`ifdef TRACE_SYNC_EN
        check($sformatf("vec%0d_sync", k), {24'd0, got_q[0]}, 32'h55);
`endif
        check($sformatf("vec%0d_hi", k), {24'd0, got_q[BPW-2]}, {24'd0, vecs[k].exp_hi});
        check($sformatf("vec%0d_lo", k), {24'd0, got_q[BPW-1]}, {24'd0, vecs[k].exp_lo});
      end
      check($sformatf("vec%0d_level", k), {27'd0, level}, 32'd0);
      check($sformatf("vec%0d_busy", k), {31'd0, busy}, 32'd0);
    end
    got_q.delete();

    // Latency from an empty FIFO: level after N, pop at N+1, tx_wr after N+2.
    ack_delay = 5;
    write_word(16'h5A5A);
    check("lat_level_n", {27'd0, level}, 32'd1);
    check("lat_busy_n", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("lat_level_n1", {27'd0, level}, 32'd0);
    check("lat_busy_n1", {31'd0, busy}, 32'd1);
    check("lat_txwr_n1", {31'd0, tx_wr}, 32'd0);
    @(negedge clk);
    check("lat_txwr_n2", {31'd0, tx_wr}, 32'd1);
    wait_idle(300);
    got_q.delete();

    // Back-to-back burst.
    ack_delay = 4;
    for (int i = 0; i < 5; i++) begin
      push_word(16'hA000 + 16'(i));
      write_word(16'hA000 + 16'(i));
    end
    wait_idle(500);
    check_stream("burst");

    // Fill with a stalled UART; the first word sits in the serialiser, so 17 writes fill 16 slots.
    ack_en = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      push_word(16'h1000 + 16'(i));
      write_word(16'h1000 + 16'(i));
    end
    check("full_level", {27'd0, level}, 32'd16);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_overflow", {31'd0, overflow}, 32'd0);
    write_word(16'hEEE0);
    write_word(16'hEEE1);
    check("drop_cnt2", {24'd0, drop_cnt}, 32'd2);
    check("drop_overflow", {31'd0, overflow}, 32'd1);
    check("drop_level", {27'd0, level}, 32'd16);

    // Write presented in the very cycle of the idle pop is still dropped.
    ack_en = 1'b1;
    ack_delay = 3;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (n >= 300) fail_timeout("wait_pop_cycle");
    check("pop_cycle_level", {27'd0, level}, 32'd16);
    in_valid = 1'b1;
    in_addr = 16'hDEAD;
    @(negedge clk);
    in_valid = 1'b0;
    check("pop_drop_cnt", {24'd0, drop_cnt}, 32'd3);
    check("pop_level", {27'd0, level}, 32'd15);
    check("pop_busy", {31'd0, busy}, 32'd1);

    // Reset while waiting for the lo byte's ack of the second word.
    for (n = 0; n < 400; n++) begin
      if (got_q.size() >= 2 * BPW) break;
      @(negedge clk);
    end
    if (n >= 400) fail_timeout("wait_lo_w");
    rst = 1'b1;
    for (int i = 0; i < 2 * BPW && i < got_q.size(); i++)
      check($sformatf("prefix_byte%0d", i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    @(negedge clk);
    check_reset_outputs("midword_rst");
    rst = 1'b0;
    @(negedge clk);
    got_q.delete();
    exp_q.delete();
    push_word(16'hBEEF);
    write_word(16'hBEEF);
    wait_idle(300);
    check_stream("beef");

    // Randomized traffic with a random-latency UART; outstanding words kept below capacity.
    ack_delay = 0;
    d0 = done_cnt;
    wr = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0 && (wr - (done_cnt - d0) / BPW) < 14) begin
        a = 16'($urandom);
        check("rand_in_ready", {31'd0, in_ready}, 32'd1);
        push_word(a);
        write_word(a);
        wr++;
      end else begin
        @(negedge clk);
      end
    end
    wait_idle(3000);
    check_stream("random");
    check("rand_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    check("rand_overflow", {31'd0, overflow}, 32'd0);

    // Drop counter saturation: 17 fills plus 260 drops.
    ack_en = 1'b0;
    for (int i = 0; i < DEPTH + 1 + 260; i++) write_word(16'(i));
    check("sat_drop_cnt", {24'd0, drop_cnt}, 32'd255);
    check("sat_overflow", {31'd0, overflow}, 32'd1);
    check("sat_level", {27'd0, level}, 32'd16);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("final_rst");
    rst = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
